// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw switch/pad inputs and conditioned mode/spotlight outputs
// Signals: SysEN, PM, MM, SM, HM (raw switches, active-high), TL, TC, TR (raw pads, active-low),
//          EN, M[1:0], SPS[1:0], FAULT (conditioned outputs)
// Modports: master drives the raw inputs, slave is the conditioner
interface input_conditioner_if;
  logic SysEN, PM, MM, SM, HM;
  logic TL, TC, TR;
  logic EN, FAULT;
  logic [1:0] M, SPS;
  modport master (output SysEN, PM, MM, SM, HM, TL, TC, TR, input EN, M, SPS, FAULT);
  modport slave (input SysEN, PM, MM, SM, HM, TL, TC, TR, output EN, M, SPS, FAULT);
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: synchronise, debounce and encode mode switches and touch pads
// Ports: clk, rst (sync active-high), io (input_conditioner_if.slave):
//   raw SysEN/PM/MM/SM/HM/TL/TC/TR in; registered EN, M, SPS, FAULT out
// Parameters: SYNC_STAGES (>=2) synchroniser depth, DEB_CYCLES (>=1) debounce length
// Macro TOUCH_HOLD_EN: when defined, SPS holds with no pad touched; otherwise it returns to Center
module input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  input_conditioner_if.slave io
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  // bit order: 0 SysEN, 1 PM, 2 MM, 3 SM, 4 HM, 5 TL, 6 TC, 7 TR; pads idle high
  localparam logic [7:0] IDLE = 8'b1110_0000;
  logic [7:0] raw, deb;
  logic [7:0] sync_q [SYNC_STAGES];
  logic [CW-1:0] cnt [8];
  logic [3:0] modes;
  logic [2:0] touch;
  logic mode_one, mode_multi, touch_one;
  logic en_n, fault_n;
  logic [1:0] m_n, sps_n, code_n, pos_n;
  assign raw = {io.TR, io.TC, io.TL, io.HM, io.SM, io.MM, io.PM, io.SysEN};
  always_comb begin
    modes = deb[4:1];
    touch = ~deb[7:5];
    mode_one = modes != 4'd0 && (modes & (modes - 4'd1)) == 4'd0;
    mode_multi = modes != 4'd0 && !mode_one;
    touch_one = touch != 3'd0 && (touch & (touch - 3'd1)) == 3'd0;
    code_n = modes[3] ? 2'b11 : modes[2] ? 2'b10 : modes[1] ? 2'b01 : 2'b00;
    pos_n = touch[0] ? 2'b00 : touch[1] ? 2'b01 : 2'b11;
    en_n = deb[0] && mode_one;
    fault_n = deb[0] && mode_multi;
    m_n = en_n ? code_n : io.M;
`ifdef TOUCH_HOLD_EN
    sps_n = touch_one ? pos_n : io.SPS;
`else
    sps_n = touch_one ? pos_n : touch == 3'd0 ? 2'b01 : io.SPS;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE;
      for (int b = 0; b < 8; b++) cnt[b] <= '0;
      deb <= IDLE;
      io.EN <= 1'b0;
      io.M <= 2'b00;
      io.SPS <= 2'b01;
      io.FAULT <= 1'b0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      for (int b = 0; b < 8; b++) begin
        if (sync_q[SYNC_STAGES-1][b] == deb[b]) cnt[b] <= '0;
        else if (cnt[b] == CW'(DEB_CYCLES - 1)) begin
          deb[b] <= sync_q[SYNC_STAGES-1][b];
          cnt[b] <= '0;
        end else cnt[b] <= cnt[b] + 1'b1;
      end
      io.EN <= en_n;
      io.M <= m_n;
      io.SPS <= sps_n;
      io.FAULT <= fault_n;
    end
  end
endmodule
